led_display_arbiter: RTL and testbench
======================================

// Module: led_display_arbiter
// PURPOSE
//  Shares the 16-LED output bank between N_REQ pattern sources (e.g. bound flasher fsm, test pattern, status).
//  Round-robin arbiter with a minimum ownership time measured in slow ticks from an internal prescaler.
//  Sits between the pattern generators and the board LED pins; the owner's pattern is driven to out, registered.
// PARAMETERS
//  N_REQ      4           number of requesters (>=2)
//  LED_W      16          LED bank width
//  TICK_DIV   25_000_000  clk cycles per slow tick (>=2)
//  HOLD_TICKS 8           minimum ownership, in ticks, before preemption by another requester (>=1)
// PORTS
//  clk      in   1            system clock
//  rst      in   1            synchronous reset, active-high
//  req      in   N_REQ        request per source, level; held while source wants the LEDs
//  pat_in   in   N_REQ*LED_W  source patterns; source i at [i*LED_W +: LED_W]
//  out      out  LED_W        registered LED drive
//  grant    out  N_REQ        one-hot current owner, all-zero when idle
//  busy     out  1            1 while a source owns the LEDs
// BEHAVIOUR
//  Reset (rst=1 at an edge): out=0, grant=0, busy=0, state=IDLE, tick counter=0, hold counter=0, rr pointer=N_REQ-1.
//  Tick gen: counter 0..TICK_DIV-1, wraps; tick=1 for one clk when counter==TICK_DIV-1. Runs in all states.
//  RR pick: search req from index ptr+1 upward, wrap, ending at ptr; first set bit wins (a lone requester can be re-picked).
//  States:
//   IDLE: grant=0, busy=0, out=0. If |req at edge: state<=OWN, grant<=onehot(pick), ptr<=pick,
//         out<=pat_in[pick], hold<=0. Grant/out therefore appear 1 cycle after req is sampled.
//   OWN:  out<=pat_in[owner] every edge (live pass-through, 1-cycle latency). On tick, hold increments,
//         saturating at HOLD_TICKS. Release (state<=IDLE, grant<=0, out<=0) when either:
//         (a) req[owner]==0  -- immediate, regardless of hold; or
//         (b) hold==HOLD_TICKS and any other req bit set.
//         Otherwise stay; a lone requester keeps ownership indefinitely, no gap.
//  Every release spends exactly 1 cycle in IDLE (LEDs blank) before the next grant; rr then favours ptr+1.
//  Simultaneous (a) and (b): single release, same behaviour.
//  Tick in same cycle as entry to OWN: not counted (hold starts at 0 on the cycle after entry).
//  req change on a non-owner while in OWN: no effect until release.
//  rst mid-OWN: next edge returns to reset values; ptr back to N_REQ-1 (req0 wins first afterwards).
//  Widths: hold counter $clog2(HOLD_TICKS+1) bits; tick counter $clog2(TICK_DIV) bits; pattern select is a mux, no arithmetic on data.
//  grant is always one-hot or zero; busy == |grant.
// TESTING  (bench params: N_REQ=4, TICK_DIV=4, HOLD_TICKS=3)
//  1 rst=1 for 3 cycles, req=4'hF -> out=0, grant=0, busy=0 throughout; first grant after release is 4'b0001.
//  2 from idle, req=4'b0100, pat2=16'hA5A5 sampled at edge k -> grant=4'b0100, busy=1, out=16'hA5A5 after edge k;
//    change pat2 to 16'h00FF -> out follows one cycle later.
//  3 req=4'hF held, distinct patterns -> grant sequence 0001,0010,0100,1000,0001; each owner holds until
//    its 3rd counted tick, then exactly 1 cycle grant=0/out=0 between owners.
//  4 owner 0 drops req after 1 tick while req1 set -> next edge grant=0, out=0; following edge grant=4'b0010.
//  5 only req3 set for 20 ticks -> grant stays 4'b1000 with no gap; then assert req0 -> release on next
//    edge (hold already saturated), grant=4'b0001 one cycle later.
//  6 rst pulsed 1 cycle while grant=4'b0100 -> next edge all outputs 0; with req=4'hF, next grant is 4'b0001.

Source files
------------

// File: rtl/led_display_arbiter.sv
// led_display_arbiter: round-robin owner of the LED bank with a minimum hold time counted in prescaled ticks
module led_display_arbiter #(
  parameter int N_REQ      = 4,
  parameter int LED_W      = 16,
  parameter int TICK_DIV   = 25_000_000,
  parameter int HOLD_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LED_W-1:0] pat_in,
  output logic [LED_W-1:0]       out,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt, w_pick;
  logic [PW-1:0]    w_idx [N_REQ];
  logic [N_REQ-1:0] w_grant_nxt;
  logic [LED_W-1:0] w_out_nxt;
  logic             w_release;
  assign w_tick = r_tick_cnt == TW'(TICK_DIV - 1);
  assign busy   = |grant;
  always_ff @(posedge clk)
    if (rst) r_tick_cnt <= '0;
    else     r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  // Candidate order starts just after the last owner; scanning from the far end lets the nearest set bit win.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) w_idx[k] = PW'((int'(r_ptr) + k + 1) % N_REQ);
    w_pick = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) if (req[w_idx[k]]) w_pick = w_idx[k];
  end
  // grant is one-hot on the owner while in OWN, so it doubles as the owner mask.
  assign w_release = !(|(req & grant)) || (r_hold == HW'(HOLD_TICKS) && |(req & ~grant));
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_grant_nxt = grant;
    w_out_nxt   = out;
    if (r_state == IDLE) begin
      if (|req) begin
        w_state_nxt = OWN;
        w_ptr_nxt   = w_pick;
        w_grant_nxt = N_REQ'(1) << w_pick;
        w_out_nxt   = pat_in[w_pick*LED_W +: LED_W];
        w_hold_nxt  = '0;
      end
    end else if (w_release) begin
      w_state_nxt = IDLE;
      w_grant_nxt = '0;
      w_out_nxt   = '0;
    end else begin
      w_out_nxt  = pat_in[r_ptr*LED_W +: LED_W];
      w_hold_nxt = (w_tick && r_hold != HW'(HOLD_TICKS)) ? r_hold + 1'b1 : r_hold;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= PW'(N_REQ - 1);
      r_hold  <= '0;
      grant   <= '0;
      out     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      grant   <= w_grant_nxt;
      out     <= w_out_nxt;
    end
endmodule

// File: tb/tb_led_display_arbiter.sv
// tb_led_display_arbiter: scoreboard bench; a cycle model queues expected out/grant per edge, sampled 1ns after the edge
module tb_led_display_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TD = 4;
  localparam int HT = 3;
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [W-1:0]   pat [N];
  logic [N*W-1:0] pat_in;
  logic [W-1:0]   out;
  logic [N-1:0]   grant;
  logic           busy;
  int             n_checks = 0;
  int             n_err = 0;
  logic [W+N-1:0] exp_q [$];
  logic [N-1:0]   seq [$];
  int             m_state, m_tick, m_hold, m_ptr;
  logic [W-1:0]   m_out;
  logic [N-1:0]   m_grant;
  assign pat_in = {pat[3], pat[2], pat[1], pat[0]};
  always #5 clk = ~clk;
  led_display_arbiter #(.N_REQ(N), .LED_W(W), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst(rst), .req(req), .pat_in(pat_in), .out(out), .grant(grant), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic model_edge();
    bit tk;
    int c, p;
    if (rst) begin
      m_state = 0; m_tick = 0; m_hold = 0; m_ptr = N - 1; m_out = '0; m_grant = '0;
      return;
    end
    tk = (m_tick == TD - 1);
    m_tick = tk ? 0 : m_tick + 1;
    if (m_state == 0) begin
      if (req != 0) begin
        p = -1;
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (p < 0 && req[c[1:0]]) p = c;
        end
        m_state = 1; m_ptr = p; m_grant = N'(1 << p); m_out = pat[p[1:0]]; m_hold = 0;
      end
    end else if (!req[m_ptr[1:0]] || (m_hold == HT && (req & ~m_grant) != 0)) begin
      m_state = 0; m_grant = '0; m_out = '0;
    end else begin
      m_out = pat[m_ptr[1:0]];
      if (tk && m_hold < HT) m_hold++;
    end
  endtask
  task automatic step();
    logic [W+N-1:0] e;
    model_edge();
    exp_q.push_back({m_out, m_grant});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_out", 32'(out), 32'(e[W+N-1:N]));
    check("sb_grant", 32'(grant), 32'(e[N-1:0]));
    check("sb_busy", 32'(busy), 32'(|e[N-1:0]));
  endtask
  initial begin
    logic [N-1:0] prev;
    int           zrun;
    rst = 1'b1;
    req = 4'hF;
    for (int i = 0; i < N; i++) pat[i] = W'(16'h1111 * (i + 1));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_rst_out", 32'(out), 0);
      check("t1_rst_grant", 32'(grant), 0);
      check("t1_rst_busy", 32'(busy), 0);
    end
    rst = 1'b0;
    prev = '0;
    zrun = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (i == 0) check("t1_first_grant", 32'(grant), 32'(4'b0001));
      if (grant == '0) zrun++;
      else begin
        if (zrun > 0) check("t3_gap_len", zrun, 1);
        zrun = 0;
        if (grant != prev) seq.push_back(grant);
      end
      prev = grant;
    end
    check("t3_count", 32'(seq.size() >= 5), 1);
    check("t3_seq0", 32'(seq[0]), 32'(4'b0001));
    check("t3_seq1", 32'(seq[1]), 32'(4'b0010));
    check("t3_seq2", 32'(seq[2]), 32'(4'b0100));
    check("t3_seq3", 32'(seq[3]), 32'(4'b1000));
    check("t3_seq4", 32'(seq[4]), 32'(4'b0001));
    req = 4'b0000;
    step();
    step();
    check("t2_idle", 32'(grant), 0);
    pat[2] = 16'hA5A5;
    req = 4'b0100;
    step();
    check("t2_grant", 32'(grant), 32'(4'b0100));
    check("t2_busy", 32'(busy), 1);
    check("t2_out", 32'(out), 32'h0000A5A5);
    pat[2] = 16'h00FF;
    #1;
    check("t2_out_registered", 32'(out), 32'h0000A5A5);
    step();
    check("t2_out_follow", 32'(out), 32'h000000FF);
    req = 4'b0000;
    step();
    step();
    req = 4'b0011;
    step();
    check("t4_grant0", 32'(grant), 32'(4'b0001));
    for (int i = 0; i < 10 && m_hold == 0; i++) step();
    check("t4_tick_seen", m_hold, 1);
    req = 4'b0010;
    step();
    check("t4_release_grant", 32'(grant), 0);
    check("t4_release_out", 32'(out), 0);
    step();
    check("t4_next_grant", 32'(grant), 32'(4'b0010));
    req = 4'b1000;
    step();
    check("t5_release", 32'(grant), 0);
    step();
    for (int i = 0; i < 80; i++) begin
      check("t5_lone_hold", 32'(grant), 32'(4'b1000));
      step();
    end
    check("t5_lone_end", 32'(grant), 32'(4'b1000));
    req = 4'b1001;
    step();
    check("t5_preempt", 32'(grant), 0);
    step();
    check("t5_new_owner", 32'(grant), 32'(4'b0001));
    req = 4'b0100;
    step();
    step();
    check("t6_owner2", 32'(grant), 32'(4'b0100));
    rst = 1'b1;
    req = 4'hF;
    step();
    check("t6_rst_out", 32'(out), 0);
    check("t6_rst_grant", 32'(grant), 0);
    check("t6_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();
    check("t6_after_rst", 32'(grant), 32'(4'b0001));
    for (int i = 0; i < 200; i++) begin
      req = N'($urandom_range(0, 15));
      pat[$urandom_range(0, N - 1)] = W'($urandom);
      rst = ($urandom_range(0, 50) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
